// File: rtl/z80_int_ctrl.sv
// Z80 interrupt controller: refresh register R, IFF1/IFF2, IM, NMI/INT arbitration.
// Latency: all outputs registered; take_req rises the cycle after the qualifying insn_done.
// Backpressure: take_req/take_nmi hold in TAKE until take_ack, then return to RUN next cycle.
module z80_int_ctrl (
    input  logic       clk,
    input  logic       reset_n,
    input  logic       m1_done,
    input  logic       insn_done,
    input  logic       insn_ei,
    input  logic       insn_di,
    input  logic       insn_retn,
    input  logic       ld_r_we,
    input  logic [7:0] ld_r_data,
    input  logic       im_we,
    input  logic [1:0] im_data,
    input  logic       nmi_n,
    input  logic       int_n,
    input  logic       take_ack,
    output logic [7:0] reg_r,
    output logic       iff1,
    output logic       iff2,
    output logic [1:0] im,
    output logic       take_req,
    output logic       take_nmi
);

    typedef enum logic {ST_RUN = 1'b0, ST_TAKE = 1'b1} state_t;

    state_t     r_state;
    state_t     w_state_nxt;
    logic [7:0] r_reg_r;
    logic       r_iff1;
    logic       r_iff2;
    logic [1:0] r_im;
    logic       r_nmi_q;
    logic       r_nmi_pend;
    logic       r_ei_shadow;
    logic       r_take_nmi;

    logic [7:0] w_reg_r_nxt;
    logic [1:0] w_im_nxt;
    logic       w_iff1_eff;
    logic       w_iff2_eff;
    logic       w_iff1_nxt;
    logic       w_iff2_nxt;
    logic       w_shadow_nxt;
    logic       w_take_nmi_nxt;
    logic       w_nmi_clr;
    logic       w_nmi_edge;
    logic       w_nmi_pend_nxt;

    // State register for the RUN/TAKE sequencer.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state <= ST_RUN;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next-state and interrupt-flag decisions taken at instruction boundaries.
    always_comb begin
        w_state_nxt    = r_state;
        w_iff1_eff     = r_iff1;
        w_iff2_eff     = r_iff2;
        w_iff1_nxt     = r_iff1;
        w_iff2_nxt     = r_iff2;
        w_shadow_nxt   = r_ei_shadow;
        w_take_nmi_nxt = r_take_nmi;
        w_nmi_clr      = 1'b0;
        case (r_state)
            ST_RUN: begin
                if (insn_done) begin
                    // Instruction effects on the enable flip-flops come first.
                    if (insn_ei) begin
                        w_iff1_eff = 1'b1;
                        w_iff2_eff = 1'b1;
                    end else if (insn_di) begin
                        w_iff1_eff = 1'b0;
                        w_iff2_eff = 1'b0;
                    end else if (insn_retn) begin
                        w_iff1_eff = r_iff2;
                    end
                    w_shadow_nxt = insn_ei;
                    if (r_nmi_pend) begin
                        // NMI saves the pre-instruction IFF1 into IFF2.
                        w_state_nxt    = ST_TAKE;
                        w_take_nmi_nxt = 1'b1;
                        w_iff2_nxt     = r_iff1;
                        w_iff1_nxt     = 1'b0;
                        w_nmi_clr      = 1'b1;
                    end else if (!int_n && w_iff1_eff && !r_ei_shadow && !insn_ei) begin
                        // Maskable interrupt is blocked on the EI boundary and the one after.
                        w_state_nxt    = ST_TAKE;
                        w_take_nmi_nxt = 1'b0;
                        w_iff1_nxt     = 1'b0;
                        w_iff2_nxt     = 1'b0;
                    end else begin
                        w_iff1_nxt = w_iff1_eff;
                        w_iff2_nxt = w_iff2_eff;
                    end
                end
            end
            ST_TAKE: begin
                if (take_ack) begin
                    w_state_nxt    = ST_RUN;
                    w_take_nmi_nxt = 1'b0;
                end
            end
            default: w_state_nxt = ST_RUN;
        endcase
    end

    // Datapath next values: R refresh counter, IM, and NMI edge latch (set beats clear).
    always_comb begin
        w_reg_r_nxt = r_reg_r;
        if (ld_r_we) begin
            w_reg_r_nxt = ld_r_data;
        end else if (m1_done) begin
            w_reg_r_nxt = {r_reg_r[7], r_reg_r[6:0] + 7'd1};
        end
        w_im_nxt = r_im;
        if (im_we && (im_data != 2'd3)) begin
            w_im_nxt = im_data;
        end
        w_nmi_edge     = r_nmi_q & ~nmi_n;
        w_nmi_pend_nxt = w_nmi_edge | (r_nmi_pend & ~w_nmi_clr);
    end

    // Architectural registers, all asynchronously cleared.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_reg_r     <= 8'h00;
            r_iff1      <= 1'b0;
            r_iff2      <= 1'b0;
            r_im        <= 2'd0;
            r_nmi_q     <= 1'b1;
            r_nmi_pend  <= 1'b0;
            r_ei_shadow <= 1'b0;
            r_take_nmi  <= 1'b0;
        end else begin
            r_reg_r     <= w_reg_r_nxt;
            r_iff1      <= w_iff1_nxt;
            r_iff2      <= w_iff2_nxt;
            r_im        <= w_im_nxt;
            r_nmi_q     <= nmi_n;
            r_nmi_pend  <= w_nmi_pend_nxt;
            r_ei_shadow <= w_shadow_nxt;
            r_take_nmi  <= w_take_nmi_nxt;
        end
    end

    assign reg_r    = r_reg_r;
    assign iff1     = r_iff1;
    assign iff2     = r_iff2;
    assign im       = r_im;
    assign take_req = (r_state == ST_TAKE);
    assign take_nmi = r_take_nmi;

endmodule

// File: tb/tb_z80_int_ctrl.sv
// Directed, table-driven bench for z80_int_ctrl.
// Each vector is held for one clock; outputs are compared 1 ns after the rising edge.
// Hand sequences cover asynchronous reset in TAKE and post-reset behaviour.
module tb_z80_int_ctrl;

    logic       clk = 1'b0;
    logic       reset_n;
    logic       m1_done, insn_done, insn_ei, insn_di, insn_retn;
    logic       ld_r_we;
    logic [7:0] ld_r_data;
    logic       im_we;
    logic [1:0] im_data;
    logic       nmi_n, int_n, take_ack;
    logic [7:0] reg_r;
    logic       iff1, iff2;
    logic [1:0] im;
    logic       take_req, take_nmi;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    z80_int_ctrl dut (
        .clk       (clk),
        .reset_n   (reset_n),
        .m1_done   (m1_done),
        .insn_done (insn_done),
        .insn_ei   (insn_ei),
        .insn_di   (insn_di),
        .insn_retn (insn_retn),
        .ld_r_we   (ld_r_we),
        .ld_r_data (ld_r_data),
        .im_we     (im_we),
        .im_data   (im_data),
        .nmi_n     (nmi_n),
        .int_n     (int_n),
        .take_ack  (take_ack),
        .reg_r     (reg_r),
        .iff1      (iff1),
        .iff2      (iff2),
        .im        (im),
        .take_req  (take_req),
        .take_nmi  (take_nmi)
    );

    typedef struct {
        logic       m1, idn, ei, di, rt, ldwe;
        logic [7:0] lddat;
        logic       imwe;
        logic [1:0] imdat;
        logic       nmin, intn, ack;
        logic [7:0] e_r;
        logic       e_iff1, e_iff2;
        logic [1:0] e_im;
        logic       e_req, e_nmi;
    } vec_t;

    vec_t vecs[$];

    function automatic vec_t mk(
        input logic m1, input logic idn, input logic ei, input logic di, input logic rt,
        input logic ldwe, input logic [7:0] lddat, input logic imwe, input logic [1:0] imdat,
        input logic nmin, input logic intn, input logic ack,
        input logic [7:0] e_r, input logic e_iff1, input logic e_iff2, input logic [1:0] e_im,
        input logic e_req, input logic e_nmi);
        vec_t v;
        v.m1 = m1; v.idn = idn; v.ei = ei; v.di = di; v.rt = rt; v.ldwe = ldwe;
        v.lddat = lddat; v.imwe = imwe; v.imdat = imdat;
        v.nmin = nmin; v.intn = intn; v.ack = ack;
        v.e_r = e_r; v.e_iff1 = e_iff1; v.e_iff2 = e_iff2; v.e_im = e_im;
        v.e_req = e_req; v.e_nmi = e_nmi;
        return v;
    endfunction

    task automatic check(input string nm, input logic [7:0] act, input logic [7:0] exp_v);
        checks++;
        if (act !== exp_v) begin
            errors++;
            $display("FAIL %s got=%h want=%h", nm, act, exp_v);
        end
    endtask

    task automatic check_all(input string tag, input logic [7:0] er, input logic e1,
                             input logic e2, input logic [1:0] em, input logic eq,
                             input logic en);
        check({tag, ".reg_r"},    reg_r,            er);
        check({tag, ".iff1"},     {7'd0, iff1},     {7'd0, e1});
        check({tag, ".iff2"},     {7'd0, iff2},     {7'd0, e2});
        check({tag, ".im"},       {6'd0, im},       {6'd0, em});
        check({tag, ".take_req"}, {7'd0, take_req}, {7'd0, eq});
        check({tag, ".take_nmi"}, {7'd0, take_nmi}, {7'd0, en});
    endtask

    task automatic run_vec(input vec_t v, input string tag);
        @(negedge clk);
        m1_done = v.m1; insn_done = v.idn; insn_ei = v.ei; insn_di = v.di; insn_retn = v.rt;
        ld_r_we = v.ldwe; ld_r_data = v.lddat; im_we = v.imwe; im_data = v.imdat;
        nmi_n = v.nmin; int_n = v.intn; take_ack = v.ack;
        @(posedge clk);
        #1;
        check_all(tag, v.e_r, v.e_iff1, v.e_iff2, v.e_im, v.e_req, v.e_nmi);
    endtask

    initial begin
        //               m1 idn ei di rt ldwe dat   imwe imd nmi int ack  r     i1 i2 im  req nmi
        // R counter wrap, load override, IM writes
        vecs.push_back(mk(0, 0, 0, 0, 0, 1, 8'h7F, 0, 2'd0, 1, 1, 0, 8'h7F, 0, 0, 2'd0, 0, 0));
        vecs.push_back(mk(1, 0, 0, 0, 0, 0, 8'h00, 0, 2'd0, 1, 1, 0, 8'h00, 0, 0, 2'd0, 0, 0));
        vecs.push_back(mk(0, 0, 0, 0, 0, 1, 8'hFF, 0, 2'd0, 1, 1, 0, 8'hFF, 0, 0, 2'd0, 0, 0));
        vecs.push_back(mk(1, 0, 0, 0, 0, 0, 8'h00, 0, 2'd0, 1, 1, 0, 8'h80, 0, 0, 2'd0, 0, 0));
        vecs.push_back(mk(1, 0, 0, 0, 0, 1, 8'h55, 0, 2'd0, 1, 1, 0, 8'h55, 0, 0, 2'd0, 0, 0));
        vecs.push_back(mk(1, 0, 0, 0, 0, 0, 8'h00, 0, 2'd0, 1, 1, 0, 8'h56, 0, 0, 2'd0, 0, 0));
        vecs.push_back(mk(0, 0, 0, 0, 0, 0, 8'h00, 1, 2'd2, 1, 1, 0, 8'h56, 0, 0, 2'd2, 0, 0));
        vecs.push_back(mk(0, 0, 0, 0, 0, 0, 8'h00, 1, 2'd3, 1, 1, 0, 8'h56, 0, 0, 2'd2, 0, 0));
        vecs.push_back(mk(0, 0, 0, 0, 0, 0, 8'h00, 1, 2'd1, 1, 1, 0, 8'h56, 0, 0, 2'd1, 0, 0));
        // INT held low: disabled, EI boundary, shadow boundary, then taken
        vecs.push_back(mk(0, 1, 0, 0, 0, 0, 8'h00, 0, 2'd0, 1, 0, 0, 8'h56, 0, 0, 2'd1, 0, 0));
        vecs.push_back(mk(0, 1, 1, 0, 0, 0, 8'h00, 0, 2'd0, 1, 0, 0, 8'h56, 1, 1, 2'd1, 0, 0));
        vecs.push_back(mk(0, 1, 0, 0, 0, 0, 8'h00, 0, 2'd0, 1, 0, 0, 8'h56, 1, 1, 2'd1, 0, 0));
        vecs.push_back(mk(0, 1, 0, 0, 0, 0, 8'h00, 0, 2'd0, 1, 0, 0, 8'h56, 0, 0, 2'd1, 1, 0));
        // In TAKE: insn_done/EI ignored, m1_done still counts; then ack back to RUN
        vecs.push_back(mk(1, 1, 1, 0, 0, 0, 8'h00, 0, 2'd0, 1, 0, 0, 8'h57, 0, 0, 2'd1, 1, 0));
        vecs.push_back(mk(0, 0, 0, 0, 0, 0, 8'h00, 0, 2'd0, 1, 1, 1, 8'h57, 0, 0, 2'd1, 0, 0));
        vecs.push_back(mk(0, 0, 0, 0, 0, 0, 8'h00, 0, 2'd0, 1, 1, 1, 8'h57, 0, 0, 2'd1, 0, 0));
        // NMI with IFF1=IFF2=1, ack, RETN restores IFF1
        vecs.push_back(mk(0, 1, 1, 0, 0, 0, 8'h00, 0, 2'd0, 1, 1, 0, 8'h57, 1, 1, 2'd1, 0, 0));
        vecs.push_back(mk(0, 1, 0, 0, 0, 0, 8'h00, 0, 2'd0, 1, 1, 0, 8'h57, 1, 1, 2'd1, 0, 0));
        vecs.push_back(mk(0, 0, 0, 0, 0, 0, 8'h00, 0, 2'd0, 0, 1, 0, 8'h57, 1, 1, 2'd1, 0, 0));
        vecs.push_back(mk(0, 1, 0, 0, 0, 0, 8'h00, 0, 2'd0, 0, 1, 0, 8'h57, 0, 1, 2'd1, 1, 1));
        vecs.push_back(mk(0, 0, 0, 0, 0, 0, 8'h00, 0, 2'd0, 1, 1, 1, 8'h57, 0, 1, 2'd1, 0, 0));
        vecs.push_back(mk(0, 1, 0, 0, 1, 0, 8'h00, 0, 2'd0, 1, 1, 0, 8'h57, 1, 1, 2'd1, 0, 0));
        // NMI beats INT; second NMI edge on the clearing cycle survives
        vecs.push_back(mk(0, 0, 0, 0, 0, 0, 8'h00, 0, 2'd0, 0, 1, 0, 8'h57, 1, 1, 2'd1, 0, 0));
        vecs.push_back(mk(0, 0, 0, 0, 0, 0, 8'h00, 0, 2'd0, 1, 0, 0, 8'h57, 1, 1, 2'd1, 0, 0));
        vecs.push_back(mk(0, 1, 0, 0, 0, 0, 8'h00, 0, 2'd0, 0, 0, 0, 8'h57, 0, 1, 2'd1, 1, 1));
        vecs.push_back(mk(0, 0, 0, 0, 0, 0, 8'h00, 0, 2'd0, 0, 1, 1, 8'h57, 0, 1, 2'd1, 0, 0));
        vecs.push_back(mk(0, 1, 0, 0, 0, 0, 8'h00, 0, 2'd0, 0, 1, 0, 8'h57, 0, 0, 2'd1, 1, 1));
        vecs.push_back(mk(0, 0, 0, 0, 0, 0, 8'h00, 0, 2'd0, 1, 1, 1, 8'h57, 0, 0, 2'd1, 0, 0));

        reset_n = 1'b0;
        m1_done = 0; insn_done = 0; insn_ei = 0; insn_di = 0; insn_retn = 0;
        ld_r_we = 0; ld_r_data = 8'h00; im_we = 0; im_data = 2'd0;
        nmi_n = 1; int_n = 1; take_ack = 0;
        repeat (2) @(posedge clk);
        #1;
        check_all("reset", 8'h00, 0, 0, 2'd0, 0, 0);
        @(negedge clk);
        reset_n = 1'b1;

        foreach (vecs[i]) begin
            run_vec(vecs[i], $sformatf("v%0d", i));
        end

        // Enter an NMI TAKE with IM=2, IFF2=1, R=0x42, then reset asynchronously.
        run_vec(mk(0, 0, 0, 0, 0, 0, 8'h00, 1, 2'd2, 1, 1, 0, 8'h57, 0, 0, 2'd2, 0, 0), "h0");
        run_vec(mk(0, 1, 1, 0, 0, 0, 8'h00, 0, 2'd0, 1, 1, 0, 8'h57, 1, 1, 2'd2, 0, 0), "h1");
        run_vec(mk(0, 0, 0, 0, 0, 1, 8'h42, 0, 2'd0, 0, 1, 0, 8'h42, 1, 1, 2'd2, 0, 0), "h2");
        run_vec(mk(0, 1, 0, 0, 0, 0, 8'h00, 0, 2'd0, 0, 1, 0, 8'h42, 0, 1, 2'd2, 1, 1), "h3");
        @(negedge clk);
        insn_done = 0; ld_r_we = 0; nmi_n = 1;
        #2;
        reset_n = 1'b0;
        #1;
        check_all("arst", 8'h00, 0, 0, 2'd0, 0, 0);
        @(negedge clk);
        reset_n = 1'b1;
        // IM write of 3 ignored; INT with IFF1=0 not taken.
        run_vec(mk(0, 1, 0, 0, 0, 0, 8'h00, 1, 2'd3, 1, 0, 0, 8'h00, 0, 0, 2'd0, 0, 0), "h4");
        run_vec(mk(1, 0, 0, 0, 0, 0, 8'h00, 0, 2'd0, 1, 1, 0, 8'h01, 0, 0, 2'd0, 0, 0), "h5");

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/z80_int_ctrl.md
Z80_INT_CTRL -- requirements
Module: z80_int_ctrl

Interface
REQ-001 clk  in  1  core clock; all state updates on rising edge.
REQ-002 reset_n  in  1  asynchronous, active-low reset.
REQ-003 m1_done  in  1  one-cycle pulse at the end of every opcode-fetch M1, including interrupt-acknowledge M1.
REQ-004 insn_done  in  1  one-cycle pulse at each instruction boundary.
REQ-005 insn_ei / insn_di / insn_retn  in  1 each  qualifiers sampled only with insn_done; at most one is set.
REQ-006 ld_r_we  in  1  LD R,A write strobe; ld_r_data  in  8  value written.
REQ-007 im_we  in  1  IM n strobe; im_data  in  2  new mode, 0..2.
REQ-008 nmi_n  in  1  NMI line, synchronous to clk, active-low, edge-triggered.
REQ-009 int_n  in  1  maskable interrupt line, active-low, level-sensitive.
REQ-010 take_ack  in  1  core has accepted the pending take request.
REQ-011 reg_r  out  8  refresh register R.
REQ-012 iff1, iff2  out  1 each  interrupt enable flip-flops.
REQ-013 im  out  2  current interrupt mode.
REQ-014 take_req  out  1  request to enter an interrupt sequence.
REQ-015 take_nmi  out  1  1 = NMI, 0 = maskable; valid while take_req=1.

Function
REQ-016 States SHALL be RUN and TAKE; take_req SHALL equal (state==TAKE).
REQ-017 On m1_done, reg_r[6:0] SHALL increment modulo 128 and reg_r[7] SHALL be unchanged; 0x7F -> 0x00, 0xFF -> 0x80.
REQ-018 ld_r_we SHALL load reg_r from ld_r_data next cycle, overriding a coincident m1_done increment.
REQ-019 im_we SHALL load im from im_data; im_data=3 SHALL leave im unchanged.
REQ-020 nmi_pend SHALL set when the registered nmi_n is 1 and the current nmi_n is 0 (falling edge), in any state.
REQ-021 In RUN, on insn_done with insn_ei: iff1=iff2=1 and ei_shadow=1.
REQ-022 In RUN, on insn_done with insn_di: iff1=iff2=0 and ei_shadow=0.
REQ-023 In RUN, on insn_done with insn_retn: iff1=iff2.
REQ-024 In RUN, insn_done without insn_ei SHALL clear ei_shadow, so maskable interrupts are blocked at the EI boundary and at the following boundary.
REQ-025 In RUN on insn_done, after the effects in REQ-021..023, if nmi_pend=1: go to TAKE with take_nmi=1, iff2=iff1 (pre-instruction value), iff1=0, and nmi_pend cleared.
REQ-026 Otherwise, if int_n=0, iff1=1 (value after this boundary's effects) and ei_shadow=0 before this boundary: go to TAKE with take_nmi=0, iff1=iff2=0.
REQ-027 NMI SHALL have priority over a maskable interrupt and SHALL ignore ei_shadow and iff1.
REQ-028 TAKE SHALL hold take_req and take_nmi stable until take_ack=1, then return to RUN next cycle.
REQ-029 In TAKE, insn_done SHALL be ignored; m1_done, ld_r_we and im_we SHALL still apply.
REQ-030 A falling edge of nmi_n coincident with the cycle that clears nmi_pend SHALL leave nmi_pend=1 (set wins).
REQ-031 take_ack in RUN SHALL be ignored.
REQ-032 Latency: take_req SHALL rise the cycle after the qualifying insn_done; there is no combinational path from inputs to outputs.

Reset
REQ-033 reset_n=0 SHALL asynchronously force reg_r=0x00, iff1=iff2=0, im=0, nmi_pend=0, ei_shadow=0, registered nmi_n=1, state=RUN, take_req=0 and take_nmi=0, including mid-TAKE.

Verification
REQ-034 reg_r=0x7F, m1_done pulse -> reg_r=0x00; load 0xFF via ld_r_we, then m1_done -> 0x80.
REQ-035 ld_r_we (0x55) and m1_done in the same cycle -> reg_r=0x55.
REQ-036 int_n=0 held, EI boundary, then a boundary with no EI -> no take_req at either; next boundary -> take_req=1, take_nmi=0, iff1=iff2=0.
REQ-037 iff1=iff2=1, nmi_n falls, then insn_done -> take_req=1, take_nmi=1, iff1=0, iff2=1; take_ack -> RUN; RETN boundary -> iff1=1.
REQ-038 NMI edge and int_n=0 with iff1=1 at the same boundary -> take_nmi=1; after take_ack a second nmi_n edge coincident with the clear -> second NMI take follows.
REQ-039 reset_n pulsed low while take_req=1 and reg_r=0x42 -> all outputs 0 immediately; im_we with im_data=3 afterwards -> im stays 0.
